// File: rtl/mips32_boot_ctrl.sv
// mips32_boot_ctrl
// Load/run/dump sequencer for the MIPS32 pipelined core. It streams a
// program image into core memory and optionally seeds REG[k] = k. It then
// releases the core and runs it under a cycle watchdog until HALT. Finally
// it streams a window of core memory back out.
//
// Ports:
//   clk1, rst_n              clock, asynchronous active-low reset
//   start                    begin a sequence (honoured only in IDLE/DONE)
//   dump_base, dump_len      dump window, captured on start (len 0 = no dump)
//   ld_valid/ld_ready        load-stream handshake
//   ld_addr/ld_data/ld_last  load beat
//   mem_we/mem_addr/mem_wdata/mem_rdata   core memory port (1-cycle read)
//   reg_we/reg_addr/reg_wdata             register-bank write port
//   core_rst_n, core_run, core_halted     core control / status
//   dp_valid/dp_ready                     dump-stream handshake
//   dp_addr/dp_data/dp_last               dump beat
//   busy, done, timeout, cycle_count      status
module mips32_boot_ctrl #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int REG_W        = 5,
  parameter int PRELOAD_REGS = 1,
  parameter int NREG_INIT    = 31,
  parameter int TIMEOUT      = 1024
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W-1:0] dump_len,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              reg_we,
  output logic [REG_W-1:0]  reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              core_rst_n,
  output logic              core_run,
  input  logic              core_halted,
  output logic              dp_valid,
  input  logic              dp_ready,
  output logic [ADDR_W-1:0] dp_addr,
  output logic [DATA_W-1:0] dp_data,
  output logic              dp_last,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycle_count
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_REGINIT  = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_DUMP_RD  = 3'd4;
  localparam logic [2:0] S_DUMP_OUT = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam bit              DO_REGS = (PRELOAD_REGS != 0) && (NREG_INIT > 0);
  // One extra bit so NREG_INIT == 2^REG_W still fits the counter.
  localparam logic [REG_W:0]  K_LAST  = (REG_W+1)'((NREG_INIT > 0) ? NREG_INIT - 1 : 0);
  localparam logic [31:0]     TMO     = 32'(TIMEOUT);

  logic [2:0]        state;
  logic [ADDR_W-1:0] base_q, len_q, idx_q;
  logic [REG_W:0]    k_q;
  logic [31:0]       cc_q;
  logic              timeout_q;
  logic [DATA_W-1:0] dp_data_q;
  logic              dp_hold_q;

  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       cc_inc;
  logic              beat_last;

  assign rd_addr   = base_q + idx_q;
  assign cc_inc    = cc_q + 32'd1;
  assign beat_last = (idx_q == len_q - ADDR_W'(1));

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      k_q       <= '0;
      cc_q      <= '0;
      timeout_q <= 1'b0;
      dp_data_q <= '0;
      dp_hold_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_LOAD;
            base_q    <= dump_base;
            len_q     <= dump_len;
            cc_q      <= '0;
            timeout_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (ld_valid && ld_last) begin
            state <= DO_REGS ? S_REGINIT : S_RUN;
            k_q   <= '0;
          end
        end
        S_REGINIT: begin
          if (k_q == K_LAST) state <= S_RUN;
          else               k_q   <= k_q + 1'b1;
        end
        S_RUN: begin
          // A halted core has not executed this cycle, so it is not counted.
          // Checking halt first also makes a same-cycle halt win over timeout.
          if (core_halted) begin
            state     <= (len_q == '0) ? S_DONE : S_DUMP_RD;
            idx_q     <= '0;
            dp_hold_q <= 1'b0;
          end else begin
            cc_q <= cc_inc;
            if (cc_inc >= TMO) begin
              timeout_q <= 1'b1;
              state     <= (len_q == '0) ? S_DONE : S_DUMP_RD;
              idx_q     <= '0;
              dp_hold_q <= 1'b0;
            end
          end
        end
        S_DUMP_RD: begin
          state     <= S_DUMP_OUT;
          dp_hold_q <= 1'b0;
        end
        S_DUMP_OUT: begin
          // Read data is only valid in the first DUMP_OUT cycle, since
          // mem_addr is released afterwards; latch it to hold it during a stall.
          if (!dp_hold_q) dp_data_q <= mem_rdata;
          if (dp_ready) begin
            idx_q     <= idx_q + 1'b1;
            dp_hold_q <= 1'b0;
            state     <= beat_last ? S_DONE : S_DUMP_RD;
          end else begin
            dp_hold_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Load writes pass straight through so an accepted beat is written in its own cycle.
  assign ld_ready  = (state == S_LOAD);
  assign mem_we    = (state == S_LOAD) && ld_valid;
  assign mem_addr  = (state == S_LOAD)    ? ld_addr :
                     (state == S_DUMP_RD) ? rd_addr : '0;
  assign mem_wdata = (state == S_LOAD) ? ld_data : '0;

  assign reg_we    = (state == S_REGINIT);
  assign reg_addr  = reg_we ? k_q[REG_W-1:0] : '0;
  assign reg_wdata = reg_we ? DATA_W'(k_q[REG_W-1:0]) : '0;

  // The core stays out of reset after RUN so its halted state survives the dump.
  assign core_rst_n = (state == S_RUN) || (state == S_DUMP_RD) ||
                      (state == S_DUMP_OUT) || (state == S_DONE);
  assign core_run   = (state == S_RUN);

  assign dp_valid = (state == S_DUMP_OUT);
  assign dp_addr  = dp_valid ? rd_addr : '0;
  assign dp_data  = (dp_valid && !dp_hold_q) ? mem_rdata : dp_data_q;
  assign dp_last  = dp_valid && beat_last;

  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);
  assign timeout     = timeout_q;
  assign cycle_count = cc_q;

endmodule

// File: doc/mips32_boot_ctrl.md
# mips32_boot_ctrl

Parametrised load/run/dump controller for the MIPS32 pipelined core. It takes a program image over a valid/ready stream and writes it into core memory. It then pre-initialises the register bank, releases the core and watches for HALT with a cycle-count watchdog. Afterwards it streams a selected memory window back out. It replaces hierarchical pokes into core memory and registers with a synthesizable sequence usable in bench and on silicon.

## Interface
- DATA_W, 32, memory/register word width
- ADDR_W, 10, memory word-address width
- REG_W, 5, register-index width
- PRELOAD_REGS, 1, 1 = run register-init phase, 0 = skip it
- NREG_INIT, 31, registers initialised (REG[k] = k, k = 0..NREG_INIT-1), ≤ 2^REG_W
- TIMEOUT, 1024, max RUN cycles before forced stop

Ports:
- clk1  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin sequence; sampled only when idle or done
- dump_base  in  ADDR_W  first dump address, captured on start
- dump_len  in  ADDR_W  dump word count, captured on start; 0 = no dump
- ld_valid / ld_ready  in / out  1  load-stream handshake
- ld_addr, ld_data, ld_last  in  ADDR_W, DATA_W, 1  load beat
- mem_we  out  1  core memory write strobe
- mem_addr, mem_wdata  out  ADDR_W, DATA_W  core memory port
- mem_rdata  in  DATA_W  synchronous read data, 1-cycle latency
- reg_we, reg_addr, reg_wdata  out  1, REG_W, DATA_W  register-bank write port
- core_rst_n  out  1  core init: low clears PC, HALTED, TAKEN_BRANCH
- core_run  out  1  core clock-enable
- core_halted  in  1  core HALTED flag
- dp_valid / dp_ready  out / in  1  dump-stream handshake
- dp_addr, dp_data, dp_last  out  ADDR_W, DATA_W, 1  dump beat
- busy, done, timeout  out  1  status
- cycle_count  out  32  RUN cycles of last or current run

## Operation
- FSM states: IDLE, LOAD, REGINIT, RUN, DUMP_RD, DUMP_OUT, DONE.
- IDLE/DONE: start=1 goes to LOAD. Entering LOAD captures dump_base/len and clears done, timeout and cycle_count. start in any other state is ignored.
- LOAD: ld_ready=1.
  - Each accepted beat drives mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data combinationally in the same cycle.
  - A beat accepted with ld_last=1 moves to REGINIT if PRELOAD_REGS, else RUN.
  - ld_valid low stalls with no write.
- REGINIT: one write per cycle, reg_addr=k, reg_wdata=k zero-extended, k=0..NREG_INIT-1, then RUN.
- core_rst_n=0 in IDLE, LOAD and REGINIT. It is 1 from RUN onward, so the halted core state is preserved through dump.
- RUN:
  - core_run=1; cycle_count increments every RUN cycle.
  - core_halted=1 leaves for DUMP_RD. This is checked before the watchdog.
  - Otherwise, cycle_count reaching TIMEOUT sets timeout=1 and leaves for DUMP_RD.
  - If dump_len==0, the next state is DONE instead of DUMP_RD.
- DUMP_RD: drive mem_addr = base+i (mod 2^ADDR_W), then go to DUMP_OUT.
- DUMP_OUT:
  - dp_valid=1; dp_data is mem_rdata captured into a register.
  - dp_addr = base+i; dp_last = (i==len-1).
  - dp_valid stays high with beat fields stable until dp_ready.
  - On handshake: i++, then DUMP_RD, or DONE after the last beat.
- DONE: done=1, busy=0. The core stays stopped (core_run=0).
- busy=1 in every state except IDLE and DONE.

## Timing
- Reset values:
  - FSM=IDLE.
  - ld_ready, mem_we, reg_we, core_rst_n, core_run, dp_valid, dp_last, busy, done and timeout are all 0.
  - mem_addr, mem_wdata, reg_addr, reg_wdata, dp_addr, dp_data and cycle_count are all 0.
- Reset asserted mid-sequence aborts immediately to IDLE. No partial write completes after rst_n falls.
- start accepted at edge N: ld_ready=1 from cycle N+1.
- REGINIT lasts exactly NREG_INIT cycles.
- The core sees core_rst_n rise and core_run=1 on the same edge.
- cycle_count saturates at TIMEOUT. A halt and a timeout on the same cycle count as a halt (timeout=0).
- Dump throughput: 1 word per 2 cycles minimum. Extra dp_ready-low cycles add 1:1.

## Test plan
- Load 9 beats: addr 0..7 = 28010078, 0c631800, 20220000, 0c631800, 2842002d, 0c631800, 24220001, fc000000; addr 120 = 85 (ld_last). Requirements:
  - exactly 9 mem_we pulses with matching addr/data;
  - then 31 reg writes with REG[k]=k;
  - then core_run=1.
- Core model raises core_halted after 20 RUN cycles, with dump_base=120, dump_len=2. Requirements:
  - cycle_count=20, timeout=0;
  - dp beats are (120, 85) then (121, model value), dp_last on the second;
  - then done=1.
- TIMEOUT=64 and core never halts → core_run drops after 64 cycles, timeout=1, cycle_count=64, dump proceeds.
- dump_base=1023, dump_len=3, ADDR_W=10 → dp_addr sequence 1023, 0, 1. Hold dp_ready low 5 cycles on the second beat → data/addr remain stable.
- rst_n pulsed low during RUN at cycle 10 → all outputs at reset values immediately. A new start restarts from LOAD with cycle_count=0.
- PRELOAD_REGS=0, dump_len=0 → no reg_we ever; on halt go straight to done=1 with no dp_valid. A start asserted while busy is ignored.
